// File: rtl/uart_apb_pkg.sv
// ---------------------------------------------------------------------------
// uart_apb_pkg
// Shared types and constants for the APB initiator that drives the UART
// register slave.
//   APB_AW / APB_DW   : APB address and data widths
//   ADDR_*            : UART slave register map
//   apb_mst_state_t   : initiator FSM states
//   apb_cmd_t         : one queued register command (write flag, addr, data)
// ---------------------------------------------------------------------------
package uart_apb_pkg;

    localparam int unsigned APB_AW = 4;
    localparam int unsigned APB_DW = 8;

    localparam logic [APB_AW-1:0] ADDR_CONFIG = 4'h0;
    localparam logic [APB_AW-1:0] ADDR_TX     = 4'h2;
    localparam logic [APB_AW-1:0] ADDR_RX     = 4'h3;
    localparam logic [APB_AW-1:0] ADDR_STATUS = 4'h4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
// Small synchronous FIFO holding pending APB commands between the host
// command port and the initiator FSM.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data : write one command (ignored while full)
//   i_pop, o_data  : o_data is the head entry; i_pop removes it (ignored while empty)
//   o_full, o_empty: occupancy flags derived from the internal entry count
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module apb_cmd_fifo
    import uart_apb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_push,
    input  apb_cmd_t i_data,
    input  logic     i_pop,
    output apb_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    apb_cmd_t      r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap on their own because DEPTH is a power of two; a
    // simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_apb_master.sv
// ---------------------------------------------------------------------------
// uart_apb_master
// APB initiator for the UART register slave (any 4-bit address / 8-bit data
// APB slave). Host commands are queued in apb_cmd_fifo, issued one at a time
// as an APB SETUP/ACCESS transfer, and answered with one response each.
// Ports:
//   pclk, preset_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata      : command payload
//   rsp_valid/rsp_ready       : response handshake
//   rsp_write/rdata/err       : response payload (rdata 0 for writes/aborts)
//   paddr/psel/penable/pwrite/pwdata, prdata/pready : APB initiator port
// Parameters:
//   CMD_DEPTH      : command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES : stalled ACCESS cycles before abort
// Optional feature (macro APB_TIMEOUT_EN):
//   defined   -> ACCESS aborts after TIMEOUT_CYCLES cycles with pready low,
//                returning rsp_err=1
//   undefined -> ACCESS waits indefinitely, rsp_err is constant 0
// ---------------------------------------------------------------------------
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [APB_AW-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_DW-1:0] pwdata,
    input  logic [APB_DW-1:0] prdata,
    input  logic              pready
);

    // Reject illegal configurations at elaboration time.
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_apb_master: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    apb_mst_state_t    r_state;
    logic [APB_AW-1:0] r_paddr;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [APB_DW-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [APB_DW-1:0] r_rsp_rdata;

    apb_cmd_t w_cmd_in;
    apb_cmd_t w_cmd_head;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_fifo_pop;

    assign w_cmd_in   = {cmd_write, cmd_addr, cmd_wdata};
    assign w_fifo_pop = (r_state == IDLE) && !w_fifo_empty;
    assign cmd_ready  = !w_fifo_full;

    apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (pclk),
        .i_rst_n (preset_n),
        .i_push  (cmd_valid),
        .i_data  (w_cmd_in),
        .i_pop   (w_fifo_pop),
        .o_data  (w_cmd_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_tmo_cnt;
    logic        r_rsp_err;
    logic        w_tmo_hit;

    // True in the ACCESS cycle whose stall would bring the count to the limit.
    assign w_tmo_hit = ((r_tmo_cnt + 16'd1) == TMO_LIMIT);
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

    // Initiator FSM. Every APB and response output is a register written
    // here; the APB address/direction/data hold their last values outside a
    // transfer, and no new command is popped while a response is pending.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_paddr   <= w_cmd_head.addr;
                        r_pwrite  <= w_cmd_head.write;
                        r_pwdata  <= w_cmd_head.wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout reached in the same cycle.
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_write <= r_pwrite;
                        r_rsp_valid <= 1'b1;
`ifdef APB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_write <= r_pwrite;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign paddr     = r_paddr;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;

endmodule
